lr35902_sio_seq: RTL and testbench

//  Bus-master sequencer for the LR35902 serial-port register block (SB at adr=1, SC at adr=0).

---
 rtl/lr35902_sio_pkg.sv | 31 +++
 rtl/lr35902_sio_buf.sv | 42 ++++
 rtl/lr35902_sio_seq.sv | 196 +++++++++++++++++++
 tb/tb_lr35902_sio_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr35902_sio_pkg.sv
// lr35902_sio_pkg
// Shared constants and state type for the LR35902 serial-port sequencer.
// - SIO_ADR_*  : register select values of the serial port (SB=1, SC=0)
// - SC_*       : SC control byte fields used to start and stop a transfer
// - sio_seq_state_t : sequencer FSM state encoding
package lr35902_sio_pkg;

    localparam logic       SIO_ADR_SB = 1'b1;
    localparam logic       SIO_ADR_SC = 1'b0;

    localparam logic [7:0] SC_START   = 8'h80;
    localparam logic [7:0] SC_INTCLK  = 8'h01;
    localparam logic [7:0] SC_STOP    = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_SB_HI   = 4'd2,
        S_SB_LO   = 4'd3,
        S_SC_HI   = 4'd4,
        S_SC_LO   = 4'd5,
        S_WAIT    = 4'd6,
        S_RD0     = 4'd7,
        S_RD1     = 4'd8,
        S_STOP_HI = 4'd9,
        S_STOP_LO = 4'd10,
        S_DONE    = 4'd11,
        S_ERR     = 4'd12
    } sio_seq_state_t;

endpackage

// File: rtl/lr35902_sio_buf.sv
// lr35902_sio_buf
// Byte buffer with one write port and one registered read port.
// A read and a write to the same address in one cycle return the old byte.
// Ports:
//   clk, reset         clock, synchronous active-high reset (read register only)
//   i_we/i_waddr/i_wdata   write strobe, address, data
//   i_re/i_raddr       read enable and address
//   o_rdata            read data, valid the cycle after i_re
module lr35902_sio_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lr35902_sio_seq.sv
// lr35902_sio_seq
// Bus master for the LR35902 serial-port registers. For each byte of a command it
// writes SB from the TX buffer, starts the shift via SC, waits for the port irq and
// reads SB back into the RX buffer.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready         command handshake (ready only in IDLE)
//   i_cmd_len, i_cmd_int            byte count (saturates at DEPTH), internal clock select
//   i_abort                         cancel a running command
//   i_txw_en/i_txw_addr/i_txw_data  TX buffer write port
//   i_rxr_addr/o_rxr_data           RX buffer read port, 1-cycle latency
//   o_sio_adr/o_sio_write/o_sio_wdata/i_sio_rdata/i_sio_irq  serial-port register bus
//   o_busy, o_done, o_err, o_count  status
//
// state     | meaning
// IDLE      | waiting for a command
// LOAD      | TX buffer read of tx[idx]
// SB_HI/LO  | write SB = tx byte
// SC_HI/LO  | write SC = start (+ internal clock)
// WAIT      | waiting for port irq, timeout counter running
// RD0/RD1   | read SB, store into rx[idx]
// STOP_HI/LO| write SC = 0 to cancel the port transfer
// DONE/ERR  | one-cycle completion pulse
module lr35902_sio_seq
    import lr35902_sio_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 8191
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [AW:0]   i_cmd_len,
    input  logic          i_cmd_int,
    input  logic          i_abort,
    input  logic          i_txw_en,
    input  logic [AW-1:0] i_txw_addr,
    input  logic [7:0]    i_txw_data,
    input  logic [AW-1:0] i_rxr_addr,
    output logic [7:0]    o_rxr_data,
    output logic          o_sio_adr,
    output logic          o_sio_write,
    output logic [7:0]    o_sio_wdata,
    input  logic [7:0]    i_sio_rdata,
    input  logic          i_sio_irq,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [AW:0]   o_count
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    // The two STOP cycles are part of the timeout budget, so err lands exactly
    // TIMEOUT cycles after the first WAIT cycle.
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 3);
    localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_MAX   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_ONE   = AW'(1);

    sio_seq_state_t r_state, w_next;
    logic [AW:0]    r_len, r_count;
    logic [AW-1:0]  r_idx;
    logic           r_int, r_abort_pend;
    logic [TW-1:0]  r_wait;
    logic [7:0]     w_tx_rdata;
    logic           w_accept, w_abort, w_last;

    assign w_accept = (r_state == S_IDLE) && i_cmd_valid;
    // An abort seen during a HI cycle is held so the LO cycle still completes.
    assign w_abort  = i_abort || r_abort_pend;
    assign w_last   = (r_count + CNT_ONE) == r_len;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = (i_cmd_len == '0) ? S_DONE : S_LOAD;
            S_LOAD:    w_next = w_abort ? S_STOP_HI : S_SB_HI;
            S_SB_HI:   w_next = S_SB_LO;
            S_SB_LO:   w_next = w_abort ? S_STOP_HI : S_SC_HI;
            S_SC_HI:   w_next = S_SC_LO;
            S_SC_LO:   w_next = w_abort ? S_STOP_HI : S_WAIT;
            S_WAIT: begin
                if (w_abort)                       w_next = S_STOP_HI;
                else if (i_sio_irq)                w_next = S_RD0;
                else if (r_int && r_wait == '0)    w_next = S_STOP_HI;
            end
            S_RD0:     w_next = w_abort ? S_STOP_HI : S_RD1;
            S_RD1:     w_next = w_abort ? S_STOP_HI : (w_last ? S_DONE : S_LOAD);
            S_STOP_HI: w_next = S_STOP_LO;
            S_STOP_LO: w_next = S_ERR;
            S_DONE:    w_next = S_IDLE;
            S_ERR:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_count      <= '0;
            r_idx        <= '0;
            r_int        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_wait       <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_len   <= (i_cmd_len > LEN_MAX) ? LEN_MAX : i_cmd_len;
                r_int   <= i_cmd_int;
                r_idx   <= '0;
                r_count <= '0;
            end

            if (r_state == S_IDLE || w_next == S_STOP_HI) begin
                r_abort_pend <= 1'b0;
            end else if (i_abort && (r_state == S_SB_HI || r_state == S_SC_HI)) begin
                r_abort_pend <= 1'b1;
            end

            if (r_state == S_SC_LO) begin
                r_wait <= WAIT_LOAD;
            end else if (r_state == S_WAIT && r_wait != '0) begin
                r_wait <= r_wait - TW'(1);
            end

            if (r_state == S_RD1) begin
                r_count <= r_count + CNT_ONE;
                if (w_next == S_LOAD && r_idx != IDX_MAX) begin
                    r_idx <= r_idx + IDX_ONE;
                end
            end
        end
    end

    // Bus outputs decode straight from the registered state so adr/wdata are
    // identical in the HI and LO cycle of each write.
    always_comb begin
        o_sio_write = 1'b0;
        o_sio_adr   = SIO_ADR_SC;
        o_sio_wdata = '0;
        case (r_state)
            S_SB_HI, S_SB_LO: begin
                o_sio_write = (r_state == S_SB_HI);
                o_sio_adr   = SIO_ADR_SB;
                o_sio_wdata = w_tx_rdata;
            end
            S_SC_HI, S_SC_LO: begin
                o_sio_write = (r_state == S_SC_HI);
                o_sio_wdata = SC_START | (r_int ? SC_INTCLK : 8'h00);
            end
            S_RD0, S_RD1: begin
                o_sio_adr   = SIO_ADR_SB;
            end
            S_STOP_HI, S_STOP_LO: begin
                o_sio_write = (r_state == S_STOP_HI);
                o_sio_wdata = SC_STOP;
            end
            default: ;
        endcase
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = (r_state == S_ERR);
    assign o_count     = r_count;

    // TX read data is captured only in LOAD and then held through SB_HI/SB_LO.
    lr35902_sio_buf #(.DEPTH(DEPTH), .AW(AW)) u_tx_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (i_txw_en),
        .i_waddr (i_txw_addr),
        .i_wdata (i_txw_data),
        .i_re    (r_state == S_LOAD),
        .i_raddr (r_idx),
        .o_rdata (w_tx_rdata)
    );

    lr35902_sio_buf #(.DEPTH(DEPTH), .AW(AW)) u_rx_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (r_state == S_RD1),
        .i_waddr (r_idx),
        .i_wdata (i_sio_rdata),
        .i_re    (1'b1),
        .i_raddr (i_rxr_addr),
        .o_rdata (o_rxr_data)
    );

endmodule

// File: tb/tb_lr35902_sio_seq.sv
// Testbench for lr35902_sio_seq: a behavioural serial-port model answers the
// register bus, a table of command vectors plus random commands are run, and the
// resulting bus writes, status pulses and RX contents are compared with values
// computed from the command and TX contents.
module tb_lr35902_sio_seq;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 8191;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_cmd_valid, i_cmd_int, i_abort, i_txw_en;
    logic [AW:0]   i_cmd_len;
    logic [AW-1:0] i_txw_addr, i_rxr_addr;
    logic [7:0]    i_txw_data;
    logic          o_cmd_ready, o_sio_adr, o_sio_write, o_busy, o_done, o_err;
    logic [7:0]    o_rxr_data, o_sio_wdata;
    logic [AW:0]   o_count;
    logic [7:0]    p_dout;
    logic          p_irq;

    lr35902_sio_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_len   (i_cmd_len),
        .i_cmd_int   (i_cmd_int),
        .i_abort     (i_abort),
        .i_txw_en    (i_txw_en),
        .i_txw_addr  (i_txw_addr),
        .i_txw_data  (i_txw_data),
        .i_rxr_addr  (i_rxr_addr),
        .o_rxr_data  (o_rxr_data),
        .o_sio_adr   (o_sio_adr),
        .o_sio_write (o_sio_write),
        .o_sio_wdata (o_sio_wdata),
        .i_sio_rdata (p_dout),
        .i_sio_irq   (p_irq),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_count     (o_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- serial-port model ----------------
    int   irq_delay = 5;
    bit   irq_en    = 1'b1;
    bit   ff_mode   = 1'b0;
    logic [7:0] p_sb, p_sc;
    logic p_prev_wr, p_on;
    int   p_cnt;

    always @(posedge clk) begin
        if (reset) begin
            p_sb <= 8'h00; p_sc <= 8'h00; p_dout <= 8'h00; p_irq <= 1'b0;
            p_prev_wr <= 1'b0; p_on <= 1'b0; p_cnt <= 0;
        end else begin
            p_irq     <= 1'b0;
            p_prev_wr <= o_sio_write;
            p_dout    <= o_sio_adr ? p_sb : p_sc;
            if (p_prev_wr && !o_sio_write) begin
                if (o_sio_adr) p_sb <= o_sio_wdata;
                else begin
                    p_sc  <= o_sio_wdata;
                    p_on  <= o_sio_wdata[7];
                    p_cnt <= irq_delay;
                end
            end else if (p_on) begin
                if (p_cnt == 0) begin
                    p_on     <= 1'b0;
                    p_sc[7]  <= 1'b0;
                    p_irq    <= irq_en;
                    p_sb     <= ff_mode ? 8'hFF : ({p_sb[3:0], p_sb[7:4]} ^ 8'hA5);
                end else begin
                    p_cnt <= p_cnt - 1;
                end
            end
        end
    end

    // Byte the far end shifts back for a given transmitted byte.
    function automatic logic [7:0] partner(input logic [7:0] t, input bit ff);
        return ff ? 8'hFF : ({t[3:0], t[7:4]} ^ 8'hA5);
    endfunction

    // ---------------- bus monitor ----------------
    logic [8:0] commits[$];
    int   m_done_n = 0, m_err_n = 0, m_wr_n = 0, m_stab_bad = 0, m_sc_n = 0;
    int   m_err_cyc = 0, m_sc_start_cyc = 0;
    bit   m_prev_wr = 1'b0;
    logic m_hi_adr;
    logic [7:0] m_hi_wdata;

    always @(negedge clk) begin
        if (reset) begin
            m_prev_wr = 1'b0;
        end else begin
            if (m_prev_wr) begin
                if (o_sio_adr !== m_hi_adr || o_sio_wdata !== m_hi_wdata || o_sio_write !== 1'b0)
                    m_stab_bad++;
                commits.push_back({o_sio_adr, o_sio_wdata});
                if (o_sio_adr == 1'b0 && o_sio_wdata[7]) begin
                    m_sc_start_cyc = cyc;
                    m_sc_n++;
                end
            end
            if (o_sio_write) begin
                m_hi_adr   = o_sio_adr;
                m_hi_wdata = o_sio_wdata;
                m_wr_n++;
            end
            m_prev_wr = o_sio_write;
            if (o_done) m_done_n++;
            if (o_err) begin
                m_err_n++;
                m_err_cyc = cyc;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_tests = 0, n_fail = 0;
    logic [7:0] tx_model [DEPTH];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic write_tx(input int a, input logic [7:0] d);
        @(negedge clk);
        i_txw_en = 1'b1; i_txw_addr = AW'(a); i_txw_data = d;
        @(negedge clk);
        i_txw_en = 1'b0;
        tx_model[a] = d;
    endtask

    task automatic rd_rx(input int a, output logic [7:0] d);
        @(negedge clk);
        i_rxr_addr = AW'(a);
        @(negedge clk);
        d = o_rxr_data;
    endtask

    task automatic start_cmd(input int len, input bit intm);
        @(negedge clk);
        i_cmd_len = (AW+1)'(len); i_cmd_int = intm; i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(o_done || o_err) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finished"}, int'(o_done || o_err), 1);
    endtask

    typedef struct {
        int len;       bit intm;   int delay;   bit ff;   bit irq_on;
        int abort_at;  bit poke;
        int exp_count; int exp_done; int exp_err; int part;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int d0, e0, nb, mism;
        logic [7:0] exp_tx [DEPTH];
        logic [8:0] expq[$];
        logic [7:0] rd;
        commits.delete();
        m_stab_bad = 0;
        irq_delay = v.delay; ff_mode = v.ff; irq_en = v.irq_on;
        d0 = m_done_n; e0 = m_err_n;
        exp_tx = tx_model;
        start_cmd(v.len, v.intm);
        if (v.poke) begin
            // tx[0] is rewritten in its LOAD cycle (old byte goes out),
            // tx[1] before it is loaded (new byte goes out).
            i_txw_en = 1'b1; i_txw_addr = 0; i_txw_data = ~exp_tx[0];
            @(negedge clk);
            i_txw_addr = 1; i_txw_data = 8'h3C;
            @(negedge clk);
            i_txw_en = 1'b0;
            tx_model[0] = ~exp_tx[0];
            tx_model[1] = 8'h3C;
            exp_tx[1]   = 8'h3C;
        end
        if (v.abort_at >= 0) begin
            repeat (v.abort_at) @(negedge clk);
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0;
        end
        wait_end(tag);
        repeat (3) @(negedge clk);
        check({tag, "_count"}, int'(o_count), v.exp_count);
        check({tag, "_done_pulses"}, m_done_n - d0, v.exp_done);
        check({tag, "_err_pulses"}, m_err_n - e0, v.exp_err);
        check({tag, "_wr_stable"}, m_stab_bad, 0);

        nb = v.exp_count;
        for (int i = 0; i < nb; i++) begin
            expq.push_back({1'b1, exp_tx[i]});
            expq.push_back({1'b0, 8'h80 | {7'd0, v.intm}});
        end
        if (v.exp_err != 0) begin
            if (v.part >= 1 && nb < DEPTH) expq.push_back({1'b1, exp_tx[nb]});
            if (v.part >= 2) expq.push_back({1'b0, 8'h80 | {7'd0, v.intm}});
            expq.push_back(9'h000);
        end
        check({tag, "_n_commits"}, commits.size(), expq.size());
        mism = 0;
        for (int i = 0; i < expq.size() && i < commits.size(); i++)
            if (commits[i] !== expq[i]) begin
                mism++;
                $display("  %s commit %0d got=%h exp=%h", tag, i, commits[i], expq[i]);
            end
        check({tag, "_commit_values"}, mism, 0);

        for (int i = 0; i < nb; i++) begin
            rd_rx(i, rd);
            check($sformatf("%s_rx%0d", tag, i), int'(rd), int'(partner(exp_tx[i], v.ff)));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [7];

    initial begin : main
        vec_t rv;
        int   w0, k, sc0, len;

        vecs[0] = '{3,  1'b1, 5,           1'b1, 1'b1, -1,  1'b0, 3,  1, 0, 0};
        vecs[1] = '{20, 1'b1, 3,           1'b0, 1'b1, -1,  1'b0, 16, 1, 0, 0};
        vecs[2] = '{16, 1'b0, 0,           1'b0, 1'b1, -1,  1'b0, 16, 1, 0, 0};
        vecs[3] = '{1,  1'b1, TIMEOUT - 4, 1'b0, 1'b1, -1,  1'b0, 1,  1, 0, 0};
        vecs[4] = '{1,  1'b1, TIMEOUT - 3, 1'b0, 1'b1, -1,  1'b0, 0,  0, 1, 2};
        vecs[5] = '{2,  1'b0, 5,           1'b0, 1'b0, 100, 1'b0, 0,  0, 1, 2};
        vecs[6] = '{3,  1'b1, 2,           1'b0, 1'b1, 1,   1'b0, 0,  0, 1, 1};

        reset = 1'b1;
        i_cmd_valid = 0; i_cmd_int = 0; i_cmd_len = '0; i_abort = 0;
        i_txw_en = 0; i_txw_addr = '0; i_txw_data = '0; i_rxr_addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready",  int'(o_cmd_ready), 1);
        check("rst_busy",   int'(o_busy), 0);
        check("rst_write",  int'(o_sio_write), 0);
        check("rst_adr",    int'(o_sio_adr), 0);
        check("rst_wdata",  int'(o_sio_wdata), 0);
        check("rst_done",   int'(o_done), 0);
        check("rst_err",    int'(o_err), 0);
        check("rst_count",  int'(o_count), 0);
        check("rst_rxdata", int'(o_rxr_data), 0);

        for (int i = 0; i < DEPTH; i++) write_tx(i, 8'($urandom));
        write_tx(0, 8'h11); write_tx(1, 8'h22); write_tx(2, 8'h33);

        for (int i = 0; i < 7; i++) begin
            if (i > 0)
                for (int a = 0; a < DEPTH; a++) write_tx(a, 8'($urandom));
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // len=0: done on the cycle after accept, no bus traffic
        w0 = m_wr_n;
        start_cmd(0, 1'b1);
        check("len0_done_next", int'(o_done), 1);
        @(negedge clk);
        check("len0_done_single", int'(o_done), 0);
        repeat (3) @(negedge clk);
        check("len0_no_write", m_wr_n - w0, 0);
        check("len0_count", int'(o_count), 0);

        // internal clock, irq suppressed: err TIMEOUT cycles after WAIT entry
        rv = '{1, 1'b1, 5, 1'b0, 1'b0, -1, 1'b0, 0, 0, 1, 2};
        run_vec(rv, "tmo");
        check("tmo_err_latency", m_err_cyc - (m_sc_start_cyc + 1), TIMEOUT);

        // TX writes while busy
        rv = '{2, 1'b1, 20, 1'b0, 1'b1, -1, 1'b1, 2, 1, 0, 0};
        run_vec(rv, "poke");

        // reset during WAIT of byte 2, then a clean command
        commits.delete();
        irq_en = 1'b1; irq_delay = 30; ff_mode = 1'b0;
        sc0 = m_sc_n;
        start_cmd(3, 1'b1);
        k = 0;
        while (m_sc_n - sc0 < 3 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_reach_byte2", m_sc_n - sc0, 3);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", int'(o_cmd_ready), 1);
        check("rst_mid_write", int'(o_sio_write), 0);
        check("rst_mid_busy",  int'(o_busy), 0);
        check("rst_mid_count", int'(o_count), 0);
        reset = 1'b0;
        rv = '{4, 1'b1, 3, 1'b0, 1'b1, -1, 1'b0, 4, 1, 0, 0};
        run_vec(rv, "after_rst");

        // random commands against the model
        for (int i = 0; i < 8; i++) begin
            for (int a = 0; a < DEPTH; a++) write_tx(a, 8'($urandom));
            len = $urandom_range(0, 24);
            rv.len = len;  rv.intm = 1'($urandom);
            rv.delay = $urandom_range(0, 12);
            rv.ff = 1'b0;  rv.irq_on = 1'b1;  rv.abort_at = -1;  rv.poke = 1'b0;
            rv.exp_count = (len > DEPTH) ? DEPTH : len;
            rv.exp_done = 1;  rv.exp_err = 0;  rv.part = 0;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
